// File: rtl/alu_exec_pkg.sv
// Shared encodings for the ALU execute/writeback sequencer.
package alu_exec_pkg;

    // ALU mode codes presented on alu_mode
    localparam logic [3:0] ALU_ORA  = 4'h0;
    localparam logic [3:0] ALU_EOR  = 4'h2;
    localparam logic [3:0] ALU_ADC  = 4'h3;
    localparam logic [3:0] ALU_STA  = 4'h4;
    localparam logic [3:0] ALU_LDA  = 4'h5;
    localparam logic [3:0] ALU_CMP  = 4'h6;
    localparam logic [3:0] ALU_SBC  = 4'h7;
    localparam logic [3:0] ALU_ASL  = 4'h8;
    localparam logic [3:0] ALU_ROL  = 4'h9;
    localparam logic [3:0] ALU_LSR  = 4'hA;
    localparam logic [3:0] ALU_ROR  = 4'hB;
    localparam logic [3:0] ALU_FLAG = 4'hC;
    localparam logic [3:0] ALU_BIT  = 4'hD;
    localparam logic [3:0] ALU_DEC  = 4'hE;
    localparam logic [3:0] ALU_INC  = 4'hF;

    // A-side operand select
    localparam logic [1:0] AREG_A    = 2'd0;
    localparam logic [1:0] AREG_X    = 2'd1;
    localparam logic [1:0] AREG_Y    = 2'd2;
    localparam logic [1:0] AREG_ZERO = 2'd3;

    // B-side operand select
    localparam logic [1:0] SRC_IMM = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_A   = 2'd2;
    localparam logic [1:0] SRC_X   = 2'd3;

    // Destination select; codes 5-7 behave as none
    localparam logic [2:0] DST_NONE = 3'd0;
    localparam logic [2:0] DST_A    = 3'd1;
    localparam logic [2:0] DST_X    = 3'd2;
    localparam logic [2:0] DST_Y    = 3'd3;
    localparam logic [2:0] DST_MEM  = 3'd4;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StExec  = 2'd2,
        StWrite = 2'd3
    } state_e;

    // Status register bit positions
    localparam int unsigned P_BIT_C = 0;
    localparam int unsigned P_BIT_Z = 1;
    localparam int unsigned P_BIT_I = 2;
    localparam int unsigned P_BIT_D = 3;
    localparam int unsigned P_BIT_B = 4;
    localparam int unsigned P_BIT_U = 5;
    localparam int unsigned P_BIT_V = 6;
    localparam int unsigned P_BIT_N = 7;

    // Bit 5 of P always reads as one
    function automatic logic [7:0] fix_p(input logic [7:0] v);
        return {v[7:6], 1'b1, v[4:0]};
    endfunction

endpackage

// File: rtl/alu_exec_regfile.sv
// Architectural A/X/Y/P registers with operand read muxes and write decode.
module alu_exec_regfile
    import alu_exec_pkg::*;
#(
    parameter logic [7:0] P_RESET = 8'h24
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_areg,
    input  logic [1:0] i_src,
    input  logic [7:0] i_imm,
    input  logic       i_wb_en,
    input  logic [2:0] i_dst,
    input  logic [7:0] i_wb_data,
    input  logic       i_wf,
    input  logic [7:0] i_flags,
    input  logic       i_idle,
    input  logic       i_p_we,
    input  logic [7:0] i_p_wdata,
    output logic [7:0] o_areg_val,
    output logic [7:0] o_src_val,
    output logic [7:0] o_reg_a,
    output logic [7:0] o_reg_x,
    output logic [7:0] o_reg_y,
    output logic [7:0] o_reg_p
);

    logic [7:0] r_a, r_x, r_y, r_p;
    logic       w_we_a, w_we_x, w_we_y, w_we_p_alu, w_we_p_ext;

    assign w_we_a     = i_wb_en && (i_dst == DST_A);
    assign w_we_x     = i_wb_en && (i_dst == DST_X);
    assign w_we_y     = i_wb_en && (i_dst == DST_Y);
    assign w_we_p_alu = i_wb_en && i_wf;
    // External P loads only land while the sequencer is idle
    assign w_we_p_ext = i_idle && i_p_we;

    // A-side and register-sourced B-side operand selection
    always_comb begin
        o_areg_val = 8'h00;
        o_src_val  = 8'h00;
        case (i_areg)
            AREG_A:  o_areg_val = r_a;
            AREG_X:  o_areg_val = r_x;
            AREG_Y:  o_areg_val = r_y;
            default: o_areg_val = 8'h00;
        endcase
        case (i_src)
            SRC_IMM: o_src_val = i_imm;
            SRC_A:   o_src_val = r_a;
            SRC_X:   o_src_val = r_x;
            default: o_src_val = 8'h00;  // memory operand is captured by the sequencer
        endcase
    end

    // Register storage with writeback and P updates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= 8'h00;
            r_x <= 8'h00;
            r_y <= 8'h00;
            r_p <= P_RESET;
        end else begin
            if (w_we_a) r_a <= i_wb_data;
            if (w_we_x) r_x <= i_wb_data;
            if (w_we_y) r_y <= i_wb_data;
            if (w_we_p_alu) begin
                r_p <= fix_p(i_flags);
            end else if (w_we_p_ext) begin
                r_p <= fix_p(i_p_wdata);
            end
        end
    end

    assign o_reg_a = r_a;
    assign o_reg_x = r_x;
    assign o_reg_y = r_y;
    assign o_reg_p = r_p;

endmodule

// File: rtl/alu_exec.sv
// Execute/writeback sequencer driving an external 6502 ALU: fetch, execute, write back.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter logic [7:0] P_RESET = 8'h24
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_req_alu,
    input  logic [2:0]  i_req_op,
    input  logic [1:0]  i_req_areg,
    input  logic [1:0]  i_req_src,
    input  logic [2:0]  i_req_dst,
    input  logic        i_req_wf,
    input  logic [7:0]  i_req_imm,
    input  logic [15:0] i_req_addr,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_ready,
    output logic [7:0]  o_alu_a,
    output logic [7:0]  o_alu_b,
    output logic [3:0]  o_alu_mode,
    output logic [7:0]  o_alu_p,
    output logic [2:0]  o_alu_op,
    input  logic [7:0]  i_alu_ar,
    input  logic [7:0]  i_alu_af,
    input  logic        i_p_we,
    input  logic [7:0]  i_p_wdata,
    output logic [7:0]  o_reg_a,
    output logic [7:0]  o_reg_x,
    output logic [7:0]  o_reg_y,
    output logic [7:0]  o_reg_p,
    output logic        o_done
);

    state_e      r_state, w_state_d;
    logic [3:0]  r_alu;
    logic [2:0]  r_op;
    logic [1:0]  r_areg;
    logic [2:0]  r_dst;
    logic        r_wf;
    logic [15:0] r_addr;
    logic [7:0]  r_operand;
    logic [7:0]  r_result;
    logic        r_done;
    logic        w_accept, w_retire;
    logic [7:0]  w_areg_val, w_src_val;

    assign w_accept = i_req_valid && (r_state == StIdle);
    assign w_retire = ((r_state == StExec) && (r_dst != DST_MEM)) ||
                      ((r_state == StWrite) && i_mem_ready);

    alu_exec_regfile #(
        .P_RESET(P_RESET)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_areg     (r_areg),
        .i_src      (i_req_src),
        .i_imm      (i_req_imm),
        .i_wb_en    (r_state == StExec),
        .i_dst      (r_dst),
        .i_wb_data  (i_alu_ar),
        .i_wf       (r_wf),
        .i_flags    (i_alu_af),
        .i_idle     (r_state == StIdle),
        .i_p_we     (i_p_we),
        .i_p_wdata  (i_p_wdata),
        .o_areg_val (w_areg_val),
        .o_src_val  (w_src_val),
        .o_reg_a    (o_reg_a),
        .o_reg_x    (o_reg_x),
        .o_reg_y    (o_reg_y),
        .o_reg_p    (o_reg_p)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_d = (i_req_src == SRC_MEM) ? StRead : StExec;
            StRead:  if (i_mem_ready) w_state_d = StExec;
            StExec:  w_state_d = (r_dst == DST_MEM) ? StWrite : StIdle;
            StWrite: if (i_mem_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and latched fields only
    always_comb begin
        o_req_ready = 1'b0;
        o_mem_rd    = 1'b0;
        o_mem_wr    = 1'b0;
        o_mem_addr  = 16'h0000;
        o_mem_wdata = 8'h00;
        o_alu_a     = 8'h00;
        o_alu_b     = 8'h00;
        o_alu_mode  = 4'h0;
        o_alu_op    = 3'h0;
        o_alu_p     = 8'h00;
        case (r_state)
            StIdle: o_req_ready = 1'b1;
            StRead: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = r_addr;
            end
            StExec: begin
                o_alu_a    = w_areg_val;
                o_alu_b    = r_operand;
                o_alu_mode = r_alu;
                o_alu_op   = r_op;
                o_alu_p    = o_reg_p;
            end
            StWrite: begin
                o_mem_wr    = 1'b1;
                o_mem_addr  = r_addr;
                o_mem_wdata = r_result;
            end
            default: ;
        endcase
    end

    // Request latch, operand capture, result capture and retire pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu     <= 4'h0;
            r_op      <= 3'h0;
            r_areg    <= AREG_A;
            r_dst     <= DST_NONE;
            r_wf      <= 1'b0;
            r_addr    <= 16'h0000;
            r_operand <= 8'h00;
            r_result  <= 8'h00;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_retire;
            if (w_accept) begin
                r_alu  <= i_req_alu;
                r_op   <= i_req_op;
                r_areg <= i_req_areg;
                r_dst  <= i_req_dst;
                r_wf   <= i_req_wf;
                r_addr <= i_req_addr;
                if (i_req_src != SRC_MEM) r_operand <= w_src_val;
            end
            if ((r_state == StRead) && i_mem_ready) r_operand <= i_mem_rdata;
            if (r_state == StExec) r_result <= i_alu_ar;
        end
    end

    assign o_done = r_done;

endmodule

// File: tb/tb_alu_exec.sv
// Randomised and directed bench for alu_exec with a behavioural ALU and memory.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_wf;
    logic [3:0]  req_alu;
    logic [2:0]  req_op, req_dst;
    logic [1:0]  req_areg, req_src;
    logic [7:0]  req_imm;
    logic [15:0] req_addr, mem_addr;
    logic        mem_rd, mem_wr, mem_ready;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  alu_a, alu_b, alu_p, alu_ar, alu_af;
    logic [3:0]  alu_mode;
    logic [2:0]  alu_op;
    logic        p_we;
    logic [7:0]  p_wdata;
    logic [7:0]  reg_a, reg_x, reg_y, reg_p;
    logic        done;

    logic [7:0]  mem     [65536];
    logic [7:0]  ref_mem [65536];
    logic [7:0]  m_a, m_x, m_y, m_p;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    alu_exec #(
        .P_RESET(8'h24)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_alu   (req_alu),
        .i_req_op    (req_op),
        .i_req_areg  (req_areg),
        .i_req_src   (req_src),
        .i_req_dst   (req_dst),
        .i_req_wf    (req_wf),
        .i_req_imm   (req_imm),
        .i_req_addr  (req_addr),
        .o_mem_addr  (mem_addr),
        .o_mem_rd    (mem_rd),
        .o_mem_wr    (mem_wr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_mode  (alu_mode),
        .o_alu_p     (alu_p),
        .o_alu_op    (alu_op),
        .i_alu_ar    (alu_ar),
        .i_alu_af    (alu_af),
        .i_p_we      (p_we),
        .i_p_wdata   (p_wdata),
        .o_reg_a     (reg_a),
        .o_reg_x     (reg_x),
        .o_reg_y     (reg_y),
        .o_reg_p     (reg_p),
        .o_done      (done)
    );

    // Behavioural 6502 ALU: returns {flags, result}
    function automatic logic [15:0] alu_ref(input logic [3:0] m, input logic [2:0] op,
                                            input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] p);
        logic [7:0] r, f;
        logic [8:0] s;
        r = a;
        f = p;
        s = 9'd0;
        case (m)
            4'h0: r = a | b;
            4'h2: r = a ^ b;
            4'h3: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, p[0]};
                r = s[7:0];
                f[0] = s[8];
                f[6] = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h4: r = a;
            4'h5: r = b;
            4'h6: begin
                s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                r = s[7:0];
                f[0] = s[8];
            end
            4'h7: begin
                s = {1'b0, a} + {1'b0, ~b} + {8'd0, p[0]};
                r = s[7:0];
                f[0] = s[8];
                f[6] = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h8: begin r = {b[6:0], 1'b0}; f[0] = b[7]; end
            4'h9: begin r = {b[6:0], p[0]}; f[0] = b[7]; end
            4'hA: begin r = {1'b0, b[7:1]}; f[0] = b[0]; end
            4'hB: begin r = {p[0], b[7:1]}; f[0] = b[0]; end
            4'hC: begin
                case (op)
                    3'd0: f[0] = 1'b0;
                    3'd1: f[0] = 1'b1;
                    3'd2: f[2] = 1'b0;
                    3'd3: f[2] = 1'b1;
                    3'd5: f[6] = 1'b0;
                    3'd6: f[3] = 1'b0;
                    3'd7: f[3] = 1'b1;
                    default: ;
                endcase
            end
            4'hD: begin f[7] = b[7]; f[6] = b[6]; f[1] = ((a & b) == 8'h00); end
            4'hE: r = b - 8'd1;
            4'hF: r = b + 8'd1;
            default: ;
        endcase
        if (m != 4'h4 && m != 4'hC && m != 4'hD) begin
            f[7] = r[7];
            f[1] = (r == 8'h00);
        end
        return {f, r};
    endfunction

    assign {alu_af, alu_ar} = alu_ref(alu_mode, alu_op, alu_a, alu_b, alu_p);

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check_value({tag, "_a"}, {24'd0, reg_a}, {24'd0, m_a});
        check_value({tag, "_x"}, {24'd0, reg_x}, {24'd0, m_x});
        check_value({tag, "_y"}, {24'd0, reg_y}, {24'd0, m_y});
        check_value({tag, "_p"}, {24'd0, reg_p}, {24'd0, m_p});
    endtask

    // Issue one operation from an IDLE cycle (#1 after an edge) and check its retirement
    task automatic run_op(input logic [3:0] alu, input logic [2:0] op, input logic [1:0] areg,
                          input logic [1:0] src, input logic [2:0] dst, input logic wf,
                          input logic [7:0] imm, input logic [15:0] addr, input int rwait,
                          input int wwait, input logic exec_pwe);
        logic [7:0]  a_v, b_v, r, f;
        logic [15:0] fr;
        int          exp_lat, lat, rcnt, wcnt, nwr;
        bit          seen_done, overlap, bad_addr;
        case (areg)
            2'd0: a_v = m_a;
            2'd1: a_v = m_x;
            2'd2: a_v = m_y;
            default: a_v = 8'h00;
        endcase
        case (src)
            2'd0: b_v = imm;
            2'd1: b_v = ref_mem[addr];
            2'd2: b_v = m_a;
            default: b_v = m_x;
        endcase
        fr = alu_ref(alu, op, a_v, b_v, m_p);
        r = fr[7:0];
        f = fr[15:8];
        case (dst)
            3'd1: m_a = r;
            3'd2: m_x = r;
            3'd3: m_y = r;
            3'd4: ref_mem[addr] = r;
            default: ;
        endcase
        if (wf) m_p = {f[7:6], 1'b1, f[4:0]};
        exp_lat = 2 + ((src == 2'd1) ? 1 + rwait : 0) + ((dst == 3'd4) ? 1 + wwait : 0);

        req_alu = alu; req_op = op; req_areg = areg; req_src = src; req_dst = dst;
        req_wf = wf; req_imm = imm; req_addr = addr; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_imm = ~imm;
        req_areg = ~areg;
        if (exec_pwe) begin
            p_we = 1'b1;
            p_wdata = 8'h00;
        end
        lat = 0; rcnt = 0; wcnt = 0; nwr = 0;
        seen_done = 0; overlap = 0; bad_addr = 0;
        while (!seen_done && lat < 64) begin
            @(negedge clk);
            lat++;
            if (lat >= 2) p_we = 1'b0;
            if (mem_rd && mem_wr) overlap = 1;
            if ((mem_rd || mem_wr) && mem_addr != addr) bad_addr = 1;
            if (mem_rd) begin
                mem_rdata = mem[mem_addr];
                mem_ready = (rcnt == rwait);
                rcnt++;
            end else if (mem_wr) begin
                mem_ready = (wcnt == wwait);
                if (mem_ready) begin
                    mem[mem_addr] = mem_wdata;
                    nwr++;
                end
                wcnt++;
            end else begin
                mem_ready = 1'b0;
            end
            if (done) seen_done = 1;
        end
        @(posedge clk);
        #1;
        p_we = 1'b0;
        mem_ready = 1'b0;
        check_value("latency", lat, exp_lat);
        check_value("rd_wr_overlap", {31'd0, overlap}, 32'd0);
        check_value("mem_addr", {31'd0, bad_addr}, 32'd0);
        check_value("write_count", nwr, (dst == 3'd4) ? 1 : 0);
        if (dst == 3'd4) check_value("mem_data", {24'd0, mem[addr]}, {24'd0, ref_mem[addr]});
        check_regs("op");
    endtask

    task automatic load_p(input logic [7:0] v);
        p_we = 1'b1;
        p_wdata = v;
        @(posedge clk);
        #1;
        p_we = 1'b0;
        m_p = {v[7:6], 1'b1, v[4:0]};
        check_value("p_we_idle", {24'd0, reg_p}, {24'd0, m_p});
    endtask

    task automatic model_reset();
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_p = 8'h24;
    endtask

    initial begin
        int acc0, acc1, dn0, dn1, n_acc, n_dn;
        bit wr_seen, rd_seen, not_ready;
        req_valid = 0; req_alu = 0; req_op = 0; req_areg = 0; req_src = 0; req_dst = 0;
        req_wf = 0; req_imm = 0; req_addr = 0; mem_ready = 0; mem_rdata = 0;
        p_we = 0; p_wdata = 0;
        for (int i = 16'h0200; i < 16'h0300; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16'h0200] = 8'hFF;
        ref_mem[16'h0200] = 8'hFF;
        model_reset();

        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_regs("reset");
        check_value("reset_ready", {31'd0, req_ready}, 32'd1);
        check_value("reset_done", {31'd0, done}, 32'd0);
        check_value("reset_mem", {30'd0, mem_rd, mem_wr}, 32'd0);
        check_value("reset_alu", {8'd0, alu_a, alu_b, alu_p}, 32'd0);

        // LDA #$50 -> A, then ADC #$50
        run_op(4'h5, 3'd5, 2'd3, 2'd0, 3'd1, 1'b0, 8'h50, 16'h0000, 0, 0, 1'b0);
        run_op(4'h3, 3'd3, 2'd0, 2'd0, 3'd1, 1'b1, 8'h50, 16'h0000, 0, 0, 1'b0);
        check_value("adc_a", {24'd0, reg_a}, 32'hA0);
        check_value("adc_p", {24'd0, reg_p}, 32'hE4);

        // INC $0200 read-modify-write with 2 read waits and 1 write wait
        run_op(4'hF, 3'd7, 2'd3, 2'd1, 3'd4, 1'b1, 8'h00, 16'h0200, 2, 1, 1'b0);
        check_value("inc_mem", {24'd0, mem[16'h0200]}, 32'h00);
        check_value("inc_zn", {30'd0, reg_p[7], reg_p[1]}, 32'd1);

        // CMP #$10 against A=$10, no destination
        run_op(4'h5, 3'd5, 2'd3, 2'd0, 3'd1, 1'b0, 8'h10, 16'h0000, 0, 0, 1'b0);
        run_op(4'h6, 3'd6, 2'd0, 2'd0, 3'd0, 1'b1, 8'h10, 16'h0000, 0, 0, 1'b0);
        check_value("cmp_a", {24'd0, reg_a}, 32'h10);
        check_value("cmp_zc", {30'd0, reg_p[1], reg_p[0]}, 32'd3);

        // LDA #$42 -> X with a P load attempted during EXEC
        run_op(4'h5, 3'd5, 2'd3, 2'd0, 3'd2, 1'b0, 8'h42, 16'h0000, 0, 0, 1'b1);
        check_value("lda_x", {24'd0, reg_x}, 32'h42);

        load_p(8'h00);
        check_value("p_we_const", {24'd0, reg_p}, 32'h20);

        // Back-to-back: two immediate loads offered continuously
        acc0 = -100; acc1 = -100; dn0 = -100; dn1 = -100; n_acc = 0; n_dn = 0;
        req_alu = 4'h5; req_op = 3'd5; req_areg = 2'd3; req_src = 2'd0; req_dst = 3'd3;
        req_wf = 1'b0; req_imm = 8'h11; req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) begin
                if (n_dn == 0) dn0 = k; else dn1 = k;
                n_dn++;
            end
            if (req_valid && req_ready) begin
                if (n_acc == 0) acc0 = k; else acc1 = k;
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc == 1) begin
                    req_dst = 3'd1;
                    req_imm = 8'h22;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        m_y = 8'h11;
        m_a = 8'h22;
        check_value("b2b_accepts", n_acc, 2);
        check_value("b2b_acc_gap", acc1 - acc0, 2);
        check_value("b2b_dones", n_dn, 2);
        check_value("b2b_done_gap", dn1 - dn0, 2);
        check_value("b2b_latency", dn0 - acc0, 2);
        @(posedge clk);
        #1;
        check_regs("b2b");

        // Randomised operations
        for (int n = 0; n < 40; n++) begin
            run_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom),
                   16'h0200 + 16'($urandom_range(0, 255)), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'b0);
        end

        // Reset while a read-modify-write is stalled in READ
        req_alu = 4'hF; req_op = 3'd7; req_areg = 2'd3; req_src = 2'd1; req_dst = 3'd4;
        req_wf = 1'b1; req_addr = 16'h0210; req_valid = 1'b1; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_value("rst_pre_rd", {31'd0, mem_rd}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_value("rst_rd_drop", {31'd0, mem_rd}, 32'd0);
        check_value("rst_addr", {16'd0, mem_addr}, 32'd0);
        check_value("rst_ready", {31'd0, req_ready}, 32'd1);
        check_regs("rst_mid");
        #4 rst_n = 1'b1;
        mem_ready = 1'b1;
        wr_seen = 0; rd_seen = 0; not_ready = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_wr) wr_seen = 1;
            if (mem_rd) rd_seen = 1;
            if (!req_ready) not_ready = 1;
        end
        mem_ready = 1'b0;
        check_value("rst_no_wr", {31'd0, wr_seen}, 32'd0);
        check_value("rst_no_rd", {31'd0, rd_seen}, 32'd0);
        check_value("rst_idle", {31'd0, not_ready}, 32'd0);
        check_regs("rst_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
